// File: rtl/asyn_fifo_pkg.sv
// Shared helpers for the dual-clock level FIFO:
// pointer width derivation and Gray/binary conversion.
package asyn_fifo_pkg;

  function automatic int calc_aw(input int depth);
    int aw;
    aw = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < depth) aw = i + 1;
    return aw;
  endfunction

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs are fine: leading zeros
  // leave the prefix-XOR of the live bits untouched.
  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: write port on wclk,
// registered read port on rclk with reset on the output.
module dp_ram #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             wclk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rclk,
  input  logic             rrstn,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [1<<AW];

  always_ff @(posedge wclk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_ptr_sync.sv
// Multi-flop bus synchroniser for Gray-coded pointers,
// clocked and reset in the destination domain.
module fifo_ptr_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++)
        chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++)
        chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/asyn_fifo_lvl.sv
// Dual-clock FIFO with Gray pointer crossing and
// pessimistic fill levels on both sides.
module asyn_fifo_lvl
  import asyn_fifo_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = DEPTH - 2,
  parameter int AE_LEVEL    = 2,
  localparam int AW         = calc_aw(DEPTH)
) (
  input  logic             wclk,
  input  logic             wrstn,
  input  logic             winc,
  input  logic [WIDTH-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  output logic [AW:0]      wlevel,
  output logic             woverflow,
  input  logic             rclk,
  input  logic             rrstn,
  input  logic             rinc,
  output logic [WIDTH-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [AW:0]      rlevel,
  output logic             runderflow
);

  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE = PW'(AE_LEVEL);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic [PW-1:0] wbin_nx;
  logic [PW-1:0] rq_gray;
  logic [31:0]   wg_nx;
  logic [31:0]   rq_bin;
  logic          w_ok;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rgray;
  logic [PW-1:0] rbin_nx;
  logic [PW-1:0] wq_gray;
  logic [31:0]   rg_nx;
  logic [31:0]   wq_bin;
  logic          r_ok;

  // write domain
  assign w_ok    = winc & ~wfull;
  assign wbin_nx = wbin + PW'(w_ok);
  assign wg_nx   = bin2gray(32'(wbin_nx));

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      wbin      <= '0;
      wgray     <= '0;
      woverflow <= 1'b0;
    end else begin
      wbin      <= wbin_nx;
      wgray     <= wg_nx[PW-1:0];
      woverflow <= winc & wfull;
    end
  end

  fifo_ptr_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_r2w (
    .clk  (wclk),
    .rstn (wrstn),
    .d    (rgray),
    .q    (rq_gray)
  );

  assign rq_bin = gray2bin(32'(rq_gray));

  // Full: writer is exactly one lap ahead of the reader.
  assign wfull = wgray ==
    {~rq_gray[PW-1:PW-2], rq_gray[PW-3:0]};

  assign wlevel       = wbin - rq_bin[PW-1:0];
  assign walmost_full = wlevel >= AF;

  // read domain
  assign r_ok    = rinc & ~rempty;
  assign rbin_nx = rbin + PW'(r_ok);
  assign rg_nx   = bin2gray(32'(rbin_nx));

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      rbin       <= '0;
      rgray      <= '0;
      runderflow <= 1'b0;
    end else begin
      rbin       <= rbin_nx;
      rgray      <= rg_nx[PW-1:0];
      runderflow <= rinc & rempty;
    end
  end

  fifo_ptr_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_w2r (
    .clk  (rclk),
    .rstn (rrstn),
    .d    (wgray),
    .q    (wq_gray)
  );

  assign wq_bin = gray2bin(32'(wq_gray));

  assign rempty        = rgray == wq_gray;
  assign rlevel        = wq_bin[PW-1:0] - rbin;
  assign ralmost_empty = rlevel <= AE;

  dp_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .wclk  (wclk),
    .we    (w_ok),
    .waddr (wbin[AW-1:0]),
    .wdata (wdata),
    .rclk  (rclk),
    .rrstn (rrstn),
    .re    (r_ok),
    .raddr (rbin[AW-1:0]),
    .rdata (rdata)
  );

  logic unused_bits;
  assign unused_bits = ^{wg_nx[31:PW], rg_nx[31:PW],
                         rq_bin[31:PW], wq_bin[31:PW]};

endmodule

// File: tb/tb_asyn_fifo_lvl.sv
// Directed bench for asyn_fifo_lvl: fill, overflow,
// underflow, sync latency, streaming and mid-run reset.
`timescale 1ns/1ps
module tb_asyn_fifo_lvl;

  logic       wclk = 1'b0;
  logic       rclk = 1'b0;
  logic       wrstn, rrstn;
  logic       winc, rinc;
  logic [7:0] wdata;
  logic       wfull, walmost_full, woverflow;
  logic       rempty, ralmost_empty, runderflow;
  logic [4:0] wlevel, rlevel;
  logic [7:0] rdata;

  bit      ren   = 1'b0;
  realtime rhalf = 13.5;

  int errors = 0;
  int checks = 0;

  asyn_fifo_lvl #(
    .WIDTH       (8),
    .DEPTH       (16),
    .SYNC_STAGES (3)
  ) dut (
    .wclk          (wclk),
    .wrstn         (wrstn),
    .winc          (winc),
    .wdata         (wdata),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .wlevel        (wlevel),
    .woverflow     (woverflow),
    .rclk          (rclk),
    .rrstn         (rrstn),
    .rinc          (rinc),
    .rdata         (rdata),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  initial forever #5 wclk = ~wclk;

  initial forever begin
    if (ren) #(rhalf) rclk = ~rclk;
    else     #1;
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (wfull !== 1'b0 || walmost_full !== 1'b0 ||
        wlevel !== 5'd0 || woverflow !== 1'b0) begin
      errors++;
      $display("FAIL %s_wside full=%b af=%b lvl=%0d ovf=%b want 0 0 0 0",
               tag, wfull, walmost_full, wlevel, woverflow);
    end
    checks++;
    if (rempty !== 1'b1 || ralmost_empty !== 1'b1 ||
        rlevel !== 5'd0 || runderflow !== 1'b0) begin
      errors++;
      $display("FAIL %s_rside empty=%b ae=%b lvl=%0d udf=%b want 1 1 0 0",
               tag, rempty, ralmost_empty, rlevel, runderflow);
    end
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL %s_rdata got=%h want=00", tag, rdata);
    end
  endtask

  task automatic wait_not_empty(input string tag, input int lim);
    int k;
    for (k = 0; k < lim; k++) begin
      @(posedge rclk); #1;
      if (!rempty) break;
    end
    checks++;
    if (rempty !== 1'b0) begin
      errors++;
      $display("FAIL %s_wait rempty=%b want=0 after %0d rclk",
               tag, rempty, lim);
    end
  endtask

  task automatic test_reset();
    winc = 0; rinc = 0; wdata = 0;
    wrstn = 0; rrstn = 0;
    #23;
    check_reset_outputs("reset");
    @(negedge wclk);
    wrstn = 1; rrstn = 1;
  endtask

  task automatic test_fill();
    logic exp_af;
    for (int i = 0; i < 16; i++) begin
      @(negedge wclk);
      winc = 1; wdata = 8'(i);
      @(posedge wclk); #1;
      exp_af = (i + 1) >= 14;
      checks++;
      if (wlevel !== 5'(i + 1) || walmost_full !== exp_af ||
          wfull !== (i == 15)) begin
        errors++;
        $display("FAIL fill_%0d lvl=%0d af=%b full=%b want %0d %b %b",
                 i, wlevel, walmost_full, wfull, i + 1, exp_af, i == 15);
      end
    end
    @(negedge wclk);
    winc = 0;
  endtask

  task automatic test_overflow();
    int k;
    @(negedge wclk);
    winc = 1; wdata = 8'hAA;
    @(posedge wclk); #1;
    checks++;
    if (woverflow !== 1'b1 || wlevel !== 5'd16 || wfull !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pulse ovf=%b lvl=%0d full=%b want 1 16 1",
               woverflow, wlevel, wfull);
    end
    @(negedge wclk);
    winc = 0;
    @(posedge wclk); #1;
    checks++;
    if (woverflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear ovf=%b want=0", woverflow);
    end
    rhalf = 13.5;
    ren = 1;
    wait_not_empty("drain", 10);
    checks++;
    if (rlevel !== 5'd16) begin
      errors++;
      $display("FAIL drain_rlevel got=%0d want=16", rlevel);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge rclk);
      rinc = 1;
      @(posedge rclk); #1;
      checks++;
      if (rdata !== 8'(i)) begin
        errors++;
        $display("FAIL drain_%0d rdata=%h want=%h", i, rdata, 8'(i));
      end
    end
    @(negedge rclk);
    rinc = 0;
    checks++;
    if (rempty !== 1'b1 || rlevel !== 5'd0) begin
      errors++;
      $display("FAIL drain_empty empty=%b lvl=%0d want 1 0",
               rempty, rlevel);
    end
    for (k = 0; k < 10; k++) begin
      @(posedge wclk); #1;
      if (wlevel == 5'd0) break;
    end
    checks++;
    if (wlevel !== 5'd0 || wfull !== 1'b0) begin
      errors++;
      $display("FAIL drain_wside lvl=%0d full=%b want 0 0",
               wlevel, wfull);
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      rinc = 1;
      @(posedge rclk); #1;
      checks++;
      if (runderflow !== 1'b1 || rdata !== 8'h0F ||
          rlevel !== 5'd0) begin
        errors++;
        $display("FAIL udf_%0d udf=%b rdata=%h lvl=%0d want 1 0f 0",
                 i, runderflow, rdata, rlevel);
      end
    end
    @(negedge rclk);
    rinc = 0;
    @(posedge rclk); #1;
    checks++;
    if (runderflow !== 1'b0) begin
      errors++;
      $display("FAIL udf_clear udf=%b want=0", runderflow);
    end
  endtask

  task automatic test_single();
    int n;
    rhalf = 6.25;
    repeat (4) @(posedge rclk);
    @(negedge wclk);
    winc = 1; wdata = 8'h33;
    @(posedge wclk); #1;
    winc = 0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge rclk); #1;
      n++;
      if (!rempty) break;
    end
    checks++;
    if (rempty !== 1'b0 || n > 5) begin
      errors++;
      $display("FAIL single_latency empty=%b edges=%0d want 0 <=5",
               rempty, n);
    end
    checks++;
    if (rlevel !== 5'd1 || ralmost_empty !== 1'b1) begin
      errors++;
      $display("FAIL single_level lvl=%0d ae=%b want 1 1",
               rlevel, ralmost_empty);
    end
    @(negedge rclk);
    rinc = 1;
    @(posedge rclk); #1;
    checks++;
    if (rdata !== 8'h33 || rempty !== 1'b1) begin
      errors++;
      $display("FAIL single_read rdata=%h empty=%b want 33 1",
               rdata, rempty);
    end
    @(negedge rclk);
    rinc = 0;
  endtask

  task automatic test_stream();
    logic [7:0] q[$];
    int wsent = 0, rgot = 0;
    int wacc = 0, racc = 0;
    int ferr = 0, derr = 0;
    rhalf = 6.25;
    fork
      begin
        for (int c = 0; c < 20000 && wsent < 1000; c++) begin
          @(negedge wclk);
          if (!wfull && $urandom_range(0, 9) < 7) begin
            winc = 1; wdata = 8'(wsent * 37 + 5);
          end else begin
            winc = 0;
          end
          @(posedge wclk); #1;
          if (winc) begin
            q.push_back(wdata);
            wsent++; wacc++;
          end
          if (woverflow || wlevel > 5'd16 ||
              int'(wlevel) < wacc - racc) ferr++;
        end
        @(negedge wclk);
        winc = 0;
      end
      begin
        for (int c = 0; c < 20000 && rgot < 1000; c++) begin
          @(negedge rclk);
          rinc = (!rempty && $urandom_range(0, 9) < 7);
          @(posedge rclk); #1;
          if (rinc) begin
            if (q.size() == 0 || rdata !== q.pop_front()) derr++;
            rgot++; racc++;
          end
          if (runderflow || rlevel > 5'd16 ||
              int'(rlevel) > wacc - racc) ferr++;
        end
        @(negedge rclk);
        rinc = 0;
      end
    join
    checks++;
    if (wsent != 1000 || rgot != 1000) begin
      errors++;
      $display("FAIL stream_count sent=%0d got=%0d want 1000 1000",
               wsent, rgot);
    end
    checks++;
    if (derr != 0) begin
      errors++;
      $display("FAIL stream_data bad_words=%0d want=0", derr);
    end
    checks++;
    if (ferr != 0) begin
      errors++;
      $display("FAIL stream_flags bad_samples=%0d want=0", ferr);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) begin
      @(negedge wclk);
      winc = 1; wdata = 8'(8'hC0 + i);
      @(posedge wclk); #1;
    end
    @(negedge wclk);
    winc = 0;
    repeat (8) @(posedge rclk);
    #1;
    checks++;
    if (rlevel !== 5'd9 || wlevel !== 5'd9) begin
      errors++;
      $display("FAIL mid_level r=%0d w=%0d want 9 9", rlevel, wlevel);
    end
    #3;
    wrstn = 0; rrstn = 0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge wclk);
    @(negedge wclk);
    wrstn = 1;
    @(negedge rclk);
    rrstn = 1;
    @(negedge wclk);
    winc = 1; wdata = 8'h5A;
    @(posedge wclk); #1;
    winc = 0;
    wait_not_empty("mid", 8);
    @(negedge rclk);
    rinc = 1;
    @(posedge rclk); #1;
    checks++;
    if (rdata !== 8'h5A || rempty !== 1'b1) begin
      errors++;
      $display("FAIL mid_read rdata=%h empty=%b want 5a 1",
               rdata, rempty);
    end
    @(negedge rclk);
    rinc = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_single();
    test_stream();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
